// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Lock support is enabled with `MEM_ARB_LOCK_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port-side and memory-side bus of the data-memory arbiter.
// Lock lines exist only with `MEM_ARB_LOCK_EN.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

  logic              p0_req,    p1_req;
  logic              p0_we,     p1_we;
  logic [ADDR_W-1:0] p0_addr,   p1_addr;
  logic [DATA_W-1:0] p0_wdata,  p1_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic              p0_lock,   p1_lock;
`endif
  logic              p0_gnt,    p1_gnt;
  logic              p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata,  p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_dout;

`ifdef MEM_ARB_LOCK_EN
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_lock, p1_lock,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    output p0_rdata, p1_rdata,
    output mem_addr, mem_din, mem_wr_en,
    input  mem_dout
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_lock, p1_lock,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    input  p0_rdata, p1_rdata,
    input  mem_addr, mem_din, mem_wr_en,
    output mem_dout
  );
`else
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    output p0_rdata, p1_rdata,
    output mem_addr, mem_din, mem_wr_en,
    input  mem_dout
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    input  p0_rdata, p1_rdata,
    input  mem_addr, mem_din, mem_wr_en,
    output mem_dout
  );
`endif

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// ptr_i names the port that wins when both request.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || ptr_i == PORT0)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the 256x8 data memory.
// `MEM_ARB_LOCK_EN adds bus-lock for read-modify-write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t        state_q, state_d;
  port_t             ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0] req, req_m, gnt, lock, we;
  logic       own;

`ifdef MEM_ARB_LOCK_EN
  assign lock = {bus.p1_lock, bus.p0_lock};
`else
  assign lock = 2'b00;
`endif

  assign req = {bus.p1_req, bus.p0_req};
  assign we  = {bus.p1_we, bus.p0_we};
  assign own = (state_q == LOCK1);

  // The lock owner is the only port visible to the picker.
  always_comb begin
    req_m = req;
    if (state_q == LOCK0) req_m = {1'b0, req[0]};
    if (state_q == LOCK1) req_m = {req[1], 1'b0};
  end

  rr_pick2 u_pick (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB: begin
        if (|gnt) begin
          ptr_d = gnt[0] ? PORT1 : PORT0;
          if (gnt[0] && lock[0]) begin
            state_d = LOCK0;
            cnt_d   = CNT_W'(1);
          end else if (gnt[1] && lock[1]) begin
            state_d = LOCK1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!req[own] || !lock[own]) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (int'(cnt_q) + 1 >= LOCK_MAX) begin
          state_d = ARB;
          cnt_d   = '0;
          ptr_d   = own ? PORT0 : PORT1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      ptr_q    <= PORT0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~we;
      if (gnt[0] && !we[0]) rdata0_q <= bus.mem_dout;
      if (gnt[1] && !we[1]) rdata1_q <= bus.mem_dout;
    end
  end

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

  // Writes are never gated by reset; the memory itself has none.
  assign bus.mem_addr  = gnt[1] ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_din   = gnt[1] ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_wr_en = |(gnt & we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 256x8 memory.
// Lock scenarios run only with `MEM_ARB_LOCK_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];

  assign bus.mem_dout = tb_mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) tb_mem[bus.mem_addr] <= bus.mem_din;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0, last1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic l);
    bus.p0_req   = r;
    bus.p0_we    = w;
    bus.p0_addr  = a;
    bus.p0_wdata = d;
`ifdef MEM_ARB_LOCK_EN
    bus.p0_lock  = l;
`else
    if (l) $display("note: lock ignored");
`endif
  endtask

  task automatic drv1(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic l);
    bus.p1_req   = r;
    bus.p1_we    = w;
    bus.p1_addr  = a;
    bus.p1_wdata = d;
`ifdef MEM_ARB_LOCK_EN
    bus.p1_lock  = l;
`else
    if (l) $display("note: lock ignored");
`endif
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic cyc(input logic eg0, input logic eg1);
    logic ev0, ev1;
    #3;
    chk("gnt0", bus.p0_gnt, eg0);
    chk("gnt1", bus.p1_gnt, eg1);
    chk("wr_en", bus.mem_wr_en,
        (eg0 & bus.p0_we) | (eg1 & bus.p1_we));
    if (eg0) chk("addr0", bus.mem_addr, bus.p0_addr);
    if (eg1) chk("addr1", bus.mem_addr, bus.p1_addr);
    ev0 = eg0 & !bus.p0_we;
    ev1 = eg1 & !bus.p1_we;
    if (eg0 && bus.p0_we) ref_mem[bus.p0_addr] = bus.p0_wdata;
    if (eg1 && bus.p1_we) ref_mem[bus.p1_addr] = bus.p1_wdata;
    if (ev0) q0.push_back(ref_mem[bus.p0_addr]);
    if (ev1) q1.push_back(ref_mem[bus.p1_addr]);
    @(posedge clk);
    #1;
    chk("rvalid0", bus.p0_rvalid, ev0);
    chk("rvalid1", bus.p1_rvalid, ev1);
    if (ev0 && q0.size() > 0) begin
      last0 = q0.pop_front();
      chk("rdata0", bus.p0_rdata, last0);
    end else begin
      chk("rdata0_hold", bus.p0_rdata, last0);
    end
    if (ev1 && q1.size() > 0) begin
      last1 = q1.pop_front();
      chk("rdata1", bus.p1_rdata, last1);
    end else begin
      chk("rdata1_hold", bus.p1_rdata, last1);
    end
  endtask

  task automatic rst_seq();
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    last0 = 8'h00;
    last1 = 8'h00;
    chk("rst_rvalid0", bus.p0_rvalid, 1'b0);
    chk("rst_rvalid1", bus.p1_rvalid, 1'b0);
    chk("rst_rdata0", bus.p0_rdata, 8'h00);
    chk("rst_rdata1", bus.p1_rdata, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset = 1'b1;
    idle();
    #1;

    // write by p0, read back by p1
    rst_seq();
    drv0(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0);
    idle();
    drv1(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    cyc(1'b0, 1'b1);
    idle();
    cyc(1'b0, 1'b0);

    // continuous contention alternates
    rst_seq();
    drv0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    drv1(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cyc(i % 2 == 0, i % 2 == 1);
    idle();

    // p1 alone moves the pointer to p0
    rst_seq();
    drv1(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    drv0(1'b1, 1'b0, 8'h12, 8'h00, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    idle();

    // alternating single-port writes and reads
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(255));
      d = 8'($urandom);
      idle();
      if (i % 2 == 0) drv0(1'b1, 1'b1, a, d, 1'b0);
      else            drv1(1'b1, 1'b1, a, d, 1'b0);
      cyc(i % 2 == 0, i % 2 == 1);
      idle();
      if (i % 2 == 0) drv1(1'b1, 1'b0, a, 8'h00, 1'b0);
      else            drv0(1'b1, 1'b0, a, 8'h00, 1'b0);
      cyc(i % 2 == 1, i % 2 == 0);
    end
    idle();

`ifdef MEM_ARB_LOCK_EN
    // read-modify-write under lock
    rst_seq();
    drv0(1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
    drv1(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    cyc(1'b1, 1'b0);
    drv0(1'b1, 1'b1, 8'h20, 8'h21, 1'b0);
    cyc(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b1);
    chk("mem20", tb_mem[8'h20], 8'h21);
    idle();

    // forced release after four locked grants
    rst_seq();
    drv0(1'b1, 1'b0, 8'h40, 8'h00, 1'b1);
    drv1(1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    idle();

    // reset while p1 holds the lock
    rst_seq();
    drv1(1'b1, 1'b0, 8'h30, 8'h00, 1'b1);
    cyc(1'b0, 1'b1);
    drv0(1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
    reset = 1'b1;
    #3;
    chk("rstlk_gnt0", bus.p0_gnt, 1'b0);
    chk("rstlk_gnt1", bus.p1_gnt, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    last0 = 8'h00;
    last1 = 8'h00;
    chk("rstlk_rvalid1", bus.p1_rvalid, 1'b0);
    cyc(1'b1, 1'b0);
    idle();
`endif

    cyc(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
